viterbi_decoder_k3: RTL
=======================

// Module: viterbi_decoder_k3
// PURPOSE
//  Hard-decision Viterbi decoder for the rate-1/2, K=3 convolutional code (G0=111, G1=101).
//  Sits directly downstream of the convolutional encoder, after the channel.
//  Consumes the serial coded stream, two bits per information bit, and recovers the information bits.
//  Uses register-exchange survivors, so the output is a fixed-latency serial bit stream.
// PARAMETERS
//  TB_LEN   16  survivor depth in information bits; also the decode latency in pairs (>=4)
//  PM_W      6  path-metric width in bits; must satisfy 2^(PM_W-1) > PM_INIT+4
//  PM_INIT  16  initial metric of states 1..3 at reset (state 0 starts at 0)
// PORTS
//  clk        in   1  single system clock, rising edge
//  reset      in   1  synchronous, active-low reset
//  code_in    in   1  coded bit; the first bit of each pair is G0, the second is G1
//  code_valid in   1  code_in is sampled when high; gaps of any length are allowed
//  data_out   out  1  decoded information bit
//  data_valid out  1  one-cycle strobe; data_out is valid while it is high
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is synchronous and active-low.
//  - Reset values (reset==0 at posedge clk):
//      data_out=0, data_valid=0, phase=0, held bit=0, fill count=0.
//      All survivor paths are set to 0. PM[0]=0 and PM[1..3]=PM_INIT.
//    Reset applied mid-stream discards any half-received pair and all survivors.
//  - State numbering: state={s1,s0}, where s0 is the newest input bit.
//    Input d moves {s1,s0} to {s0,d} and emits g0=d^s0^s1, g1=d^s1.
//  - Pairing:
//      Sampled bit with phase=0: held, and phase becomes 1.
//      Sampled bit with phase=1: completes the pair {held,code_in}; ACS runs on that same edge and phase becomes 0.
//      Cycles with code_valid=0 change nothing.
//  - Branch metric: Hamming distance (0..2) between the received pair and the expected {g0,g1}.
//  - ACS, per new state ns={a,b}:
//      Predecessors are {0,a} and {1,a}; the decided input bit is b.
//      cand = PM[pred] + BM. The smaller cand wins; on a tie the {0,a} predecessor wins.
//      The survivor becomes path[ns] = {path[winner][TB_LEN-2:0], b}.
//  - Normalisation: on every ACS, the minimum of the four new metrics is subtracted from all four.
//    Stored metrics therefore have minimum 0 and never wrap. Arithmetic is unsigned PM_W bits.
//  - Output: at each ACS edge, best = the state with the minimum pre-update PM (lowest index on a tie).
//    If fill count == TB_LEN: data_out <= path[best][TB_LEN-1] and data_valid <= 1.
//    Otherwise the fill count is incremented, saturating at TB_LEN.
//    data_valid is 0 on every other cycle.
//  - Latency: the bit for pair j is emitted on the ACS edge of pair j+TB_LEN and is visible on the following cycle.
//    The first TB_LEN pairs produce no output.
//  - No flush input: the tail bits are released only by further pairs. Upstream appends TB_LEN zero pairs to drain the decoder.
// STRUCTURE
//  - Shared package viterbi_pkg:
//      localparam K=3 and NUM_STATES=4; generator constants G0=3'b111, G1=3'b101.
//      Function exp_out(state,d) returning {g0,g1}; function hamming2.
//      The encoder and this decoder both import it, so the bit order is defined in one place.
//  - Sub-module viterbi_acs: one instance per state, 4 instances in total.
//      Inputs: two predecessor metrics and two branch metrics.
//      Outputs: the unnormalised new metric and the decision bit.
//  - The top level holds the pair deserialiser, the min-finder and normalisation, the register-exchange array, and the fill counter/output register.
// TESTING
//  1. Info bits 1,0,1,1,0,0 are encoded as 11 10 00 01 01 11, followed by TB_LEN pairs of 00.
//     The bits are fed with code_valid=1 throughout.
//     Required: data_out = 1,0,1,1,0,0 then zeros; the first data_valid occurs on the cycle after pair TB_LEN is completed.
//  2. The same stream with the 4th coded bit (pair 1, G1) flipped 0 to 1.
//     Required: the output is identical to test 1 (a single error is corrected).
//  3. 1000 random info bits with random code_valid gaps of 0 to 3 cycles.
//     Required: the output matches the input delayed by TB_LEN pairs, with exactly one data_valid per pair.
//  4. A stream of 200 pairs of 11 (non-codeword noise).
//     Required: all PM values stay below 2^(PM_W-1), the minimum PM equals 0 after every ACS, and there are no X values.
//  5. reset=0 for one cycle after 5 coded bits (mid-pair), then test 1 is replayed.
//     Required: data_valid=0 until the fill completes, and the output equals test 1 exactly.
//  6. Tie check: the pair 11 is fed with only PM[0]=0 and the others at PM_INIT.
//     Required: the winners and decisions follow the "lower predecessor" and "lowest state" rules, and best=0.

Source files
------------

// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3, rate-1/2 convolutional code (G0=111, G1=101).
// Encoder and decoder both import this so the coded bit order lives in one place.
package viterbi_pkg;

    localparam int unsigned K          = 3;
    localparam int unsigned NUM_STATES = 4;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    // state = {s1,s0}; taps are ordered {d, s0, s1} against the generator bits.
    function automatic logic [1:0] exp_out(input logic [1:0] state, input logic d);
        logic [K-1:0] taps;
        taps = {d, state[0], state[1]};
        return {^(taps & G0), ^(taps & G1)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[0]} + {1'b0, x[1]};
    endfunction

endpackage

// File: rtl/viterbi_decoder_k3_if.sv
// Serial coded-bit input and decoded-bit output of the K=3 Viterbi decoder.
interface viterbi_decoder_k3_if;

    logic code_in;
    logic code_valid;
    logic data_out;
    logic data_valid;

    modport master (
        output code_in,
        output code_valid,
        input  data_out,
        input  data_valid
    );

    modport slave (
        input  code_in,
        input  code_valid,
        output data_out,
        output data_valid
    );

endinterface

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; ties go to the {0,a} predecessor.
module viterbi_acs #(
    parameter int unsigned PM_W = 6
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W-1:0] pm_new,
    output logic            dec
);

    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;

    always_comb begin
        cand0  = pm0 + PM_W'(bm0);
        cand1  = pm1 + PM_W'(bm1);
        dec    = (cand1 < cand0);
        pm_new = dec ? cand1 : cand0;
    end

endmodule

// File: rtl/viterbi_decoder_k3.sv
// Hard-decision register-exchange Viterbi decoder for the K=3 rate-1/2 code.
// Output latency is TB_LEN pairs; the first TB_LEN pairs only fill the survivors.
module viterbi_decoder_k3
    import viterbi_pkg::*;
#(
    parameter int unsigned TB_LEN  = 16,
    parameter int unsigned PM_W    = 6,
    parameter int unsigned PM_INIT = 16
) (
    input logic                 clk,
    input logic                 reset,
    viterbi_decoder_k3_if.slave bus
);

    localparam int unsigned FILL_W = $clog2(TB_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TB_LEN);

    logic              phase_q;
    logic              held_q;
    logic [PM_W-1:0]   pm_q [NUM_STATES];
    logic [TB_LEN-1:0] path_q [NUM_STATES];
    logic [FILL_W-1:0] fill_q;
    logic              data_out_q;
    logic              data_valid_q;

    logic [1:0]            rx_pair;
    logic [1:0]            bm0 [NUM_STATES];
    logic [1:0]            bm1 [NUM_STATES];
    logic [PM_W-1:0]       pm_raw [NUM_STATES];
    logic [NUM_STATES-1:0] dec;
    logic [PM_W-1:0]       pm_min;
    logic [1:0]            best;
    logic [1:0]            win;
    logic [TB_LEN-1:0]     path_next [NUM_STATES];

    assign rx_pair = {held_q, bus.code_in};

    // New state {a,b} is reached from {0,a} or {1,a} with input bit b.
    always_comb begin
        for (int ns = 0; ns < NUM_STATES; ns++) begin
            bm0[ns] = hamming2(rx_pair, exp_out({1'b0, 1'(ns >> 1)}, 1'(ns & 1)));
            bm1[ns] = hamming2(rx_pair, exp_out({1'b1, 1'(ns >> 1)}, 1'(ns & 1)));
        end
    end

    for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
        viterbi_acs #(
            .PM_W(PM_W)
        ) u_acs (
            .pm0   (pm_q[g / 2]),
            .pm1   (pm_q[g / 2 + 2]),
            .bm0   (bm0[g]),
            .bm1   (bm1[g]),
            .pm_new(pm_raw[g]),
            .dec   (dec[g])
        );
    end

    always_comb begin
        pm_min = pm_raw[0];
        best   = 2'd0;
        win    = 2'd0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_raw[i] < pm_min) pm_min = pm_raw[i];
            if (pm_q[i] < pm_q[best]) best = 2'(i);
        end
        for (int ns = 0; ns < NUM_STATES; ns++) begin
            win           = {dec[ns], 1'(ns >> 1)};
            path_next[ns] = {path_q[win][TB_LEN-2:0], 1'(ns & 1)};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q      <= 1'b0;
            held_q       <= 1'b0;
            fill_q       <= '0;
            data_out_q   <= 1'b0;
            data_valid_q <= 1'b0;
            for (int i = 0; i < NUM_STATES; i++) begin
                path_q[i] <= '0;
                pm_q[i]   <= (i == 0) ? '0 : PM_W'(PM_INIT);
            end
        end else begin
            data_valid_q <= 1'b0;
            if (bus.code_valid) begin
                if (!phase_q) begin
                    held_q  <= bus.code_in;
                    phase_q <= 1'b1;
                end else begin
                    phase_q <= 1'b0;
                    for (int i = 0; i < NUM_STATES; i++) begin
                        pm_q[i]   <= pm_raw[i] - pm_min;
                        path_q[i] <= path_next[i];
                    end
                    // Output uses the pre-update survivors of the best pre-update state.
                    if (fill_q == FILL_MAX) begin
                        data_out_q   <= path_q[best][TB_LEN-1];
                        data_valid_q <= 1'b1;
                    end else begin
                        fill_q <= fill_q + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;

endmodule
